// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and master FSM state type, used by both master and slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_INCR8  = 3'b101
  } hburst_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_BUSY,
    ST_LAST,
    ST_ERR
  } mst_state_t;

  // Unsupported codes (INCR, 100, 110, 111) collapse to a single beat.
  function automatic logic [3:0] burst_beats(input logic [2:0] code);
    logic [3:0] n;
    n = 4'd1;
    if (code == HBURST_WRAP4 || code == HBURST_INCR4) n = 4'd4;
    if (code == HBURST_INCR8) n = 4'd8;
    return n;
  endfunction

  function automatic logic [2:0] burst_code(input logic [2:0] code);
    logic [2:0] c;
    c = HBURST_SINGLE;
    if (code == HBURST_WRAP4 || code == HBURST_INCR4 || code == HBURST_INCR8) c = code;
    return c;
  endfunction

endpackage

// File: rtl/ahb_master_addr_gen.sv
// Next-beat address: +4 for incrementing bursts, HADDR[3:2] wrap for WRAP4,
// and 1 KB boundary detection for INCR4/INCR8.
module ahb_master_addr_gen
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_burst,
  output logic [ADDR_W-1:0] o_next_addr,
  output logic              o_cross_1k
);

  logic [ADDR_W-1:0] w_incr;
  logic [1:0]        w_wrap;

  always_comb begin
    w_incr      = i_addr + ADDR_W'(4);
    w_wrap      = i_addr[3:2] + 2'd1;
    o_next_addr = w_incr;
    if (i_burst == HBURST_WRAP4) o_next_addr = {i_addr[ADDR_W-1:4], w_wrap, i_addr[1:0]};
    o_cross_1k  = (i_burst == HBURST_INCR4 || i_burst == HBURST_INCR8) &&
                  (w_incr[ADDR_W-1:10] != i_addr[ADDR_W-1:10]);
  end

endmodule

// File: rtl/ahb_master.sv
// AHB-Lite burst master: command in, pipelined NONSEQ/SEQ/BUSY beats out,
// write-beat and read-beat streams, done/err completion pulses.
module ahb_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err
);

  mst_state_t        r_state;
  htrans_t           r_htrans;
  logic [ADDR_W-1:0] r_haddr;
  logic              r_hwrite;
  logic [2:0]        r_hburst;
  logic [DATA_W-1:0] r_hwdata;
  logic [3:0]        r_beats;
  logic              r_first;
  logic              r_locked;
  logic              r_dp_valid;
  logic              r_dp_write;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              r_done;
  logic              r_err;
  logic              r_cmd_ready;

  logic [ADDR_W-1:0] w_next_addr;
  logic              w_cross;
  logic              w_busy;
  logic              w_accept;
  logic              w_dp_err;

  ahb_master_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .i_addr      (r_haddr),
    .i_burst     (r_hburst),
    .o_next_addr (w_next_addr),
    .o_cross_1k  (w_cross)
  );

  // A pending write SEQ turns into BUSY while no write word is offered; once a
  // transfer type has been shown during a wait state it is frozen (r_locked / ST_BUSY).
  always_comb begin
    w_busy   = (r_state == ST_BUSY) ||
               (r_state == ST_ACTIVE && r_hwrite && !r_first && !r_locked && !wdata_valid);
    w_accept = (r_state == ST_ACTIVE) && !w_busy && HREADY;
    w_dp_err = r_dp_valid && HRESP && !HREADY;
  end

  assign HADDR       = r_haddr;
  assign HTRANS      = w_busy ? HTRANS_BUSY : r_htrans;
  assign HWRITE      = r_hwrite;
  assign HSIZE       = HSIZE_WORD;
  assign HBURST      = r_hburst;
  assign HWDATA      = r_hwdata;
  assign wdata_ready = w_accept && r_hwrite;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign done        = r_done;
  assign err         = r_err;
  assign cmd_ready   = r_cmd_ready;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state       <= ST_IDLE;
      r_htrans      <= HTRANS_IDLE;
      r_haddr       <= '0;
      r_hwrite      <= 1'b0;
      r_hburst      <= HBURST_SINGLE;
      r_hwdata      <= '0;
      r_beats       <= '0;
      r_first       <= 1'b0;
      r_locked      <= 1'b0;
      r_dp_valid    <= 1'b0;
      r_dp_write    <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_cmd_ready   <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_rdata_valid <= 1'b0;
      if (HREADY) r_dp_valid <= 1'b0;
      if (HREADY && r_dp_valid && !HRESP && !r_dp_write) begin
        r_rdata       <= HRDATA;
        r_rdata_valid <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (r_cmd_ready && cmd_valid && (!cmd_write || wdata_valid)) begin
            r_cmd_ready <= 1'b0;
            r_state     <= ST_ACTIVE;
            r_htrans    <= HTRANS_NONSEQ;
            r_haddr     <= cmd_addr & ~(ADDR_W'(3));
            r_hwrite    <= cmd_write;
            r_hburst    <= burst_code(cmd_burst);
            r_beats     <= burst_beats(cmd_burst);
            r_first     <= 1'b1;
            r_locked    <= 1'b0;
          end
        end
        ST_ACTIVE, ST_BUSY: begin
          if (w_dp_err) begin
            r_state  <= ST_ERR;
            r_htrans <= HTRANS_IDLE;
          end else if (w_accept) begin
            r_dp_valid <= 1'b1;
            r_dp_write <= r_hwrite;
            r_first    <= 1'b0;
            r_locked   <= 1'b0;
            if (r_hwrite) r_hwdata <= wdata;
            if (r_beats == 4'd1) begin
              r_state  <= ST_LAST;
              r_htrans <= HTRANS_IDLE;
            end else begin
              r_beats <= r_beats - 4'd1;
              r_haddr <= w_next_addr;
              if (w_cross) begin
                r_htrans <= HTRANS_NONSEQ;
                r_hburst <= HBURST_INCR;
              end else begin
                r_htrans <= HTRANS_SEQ;
              end
            end
          end else if (r_state == ST_BUSY) begin
            if (HREADY) r_state <= ST_ACTIVE;
          end else if (!HREADY) begin
            if (w_busy) r_state <= ST_BUSY;
            else        r_locked <= 1'b1;
          end
        end
        ST_LAST: begin
          if (w_dp_err) begin
            r_state <= ST_ERR;
          end else if (HREADY) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (HREADY) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master: a small AHB slave and write-word source,
// driven on the falling edge and observed 1 time unit later.
module tb_ahb_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_burst;
  logic [31:0] wdata;
  logic        wdata_valid, wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid, done, err;

  ahb_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .wdata(wdata), .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready), .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err)
  );

  always #5 HCLK = ~HCLK;

  int n_vec = 0, n_bad = 0;

  int          wait_beat, err_beat, gap_idx, gap_left, n_words, w_idx, err_stage, dp_beat;
  logic [31:0] rd_base, dp_addr;
  logic [31:0] wq [16];
  logic        rst_pending, cmd_pend, cmd_taken, dp_valid, dp_write, wait_done;

  logic [31:0] acc_addr [16];
  logic [1:0]  acc_trans [16];
  logic [2:0]  acc_burst [16];
  logic [31:0] rd_vals [16], wd_vals [16];
  int          n_acc, n_rd, n_wd, n_done, n_err, busy_cnt, busy_bad, cyc, first_cyc, done_cyc;
  int          lone_err, ready_at_done, ready_after_done;
  logic [31:0] wait_addr, busy_addr;
  logic [1:0]  wait_trans, post_err_trans;
  logic        prev_done, prev_errcyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wait_beat = 0; err_beat = 0; gap_idx = -1; gap_left = 0; n_words = 0; w_idx = 0;
    err_stage = 0; wait_done = 1'b0; rd_base = '0;
    n_acc = 0; n_rd = 0; n_wd = 0; n_done = 0; n_err = 0; busy_cnt = 0; busy_bad = 0;
    first_cyc = 0; done_cyc = 0; lone_err = 0; ready_at_done = 0; ready_after_done = 0;
    wait_addr = '0; busy_addr = '0; wait_trans = '0; post_err_trans = 2'b11;
    prev_done = 1'b0; prev_errcyc = 1'b0;
  endtask

  task automatic cycle();
    @(negedge HCLK);
    HRESETn = !rst_pending;
    if (cmd_taken) begin cmd_valid = 1'b0; cmd_taken = 1'b0; end
    if (cmd_pend)  begin cmd_valid = 1'b1; cmd_pend = 1'b0; end
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (dp_valid && dp_beat == err_beat) begin
      HRESP  = 1'b1;
      HREADY = (err_stage != 0);
    end else if (dp_valid && dp_beat == wait_beat && !wait_done) begin
      HREADY = 1'b0;
    end
    HRDATA      = dp_valid ? (((dp_addr - rd_base) >> 2) + 32'd1) : 32'h0;
    wdata_valid = (w_idx < n_words) && !(w_idx == gap_idx && gap_left > 0);
    wdata       = (w_idx < 16) ? wq[w_idx] : 32'h0;
    #1;
    cyc++;
    if (prev_done)   ready_after_done = int'(cmd_ready);
    if (prev_errcyc) post_err_trans = HTRANS;
    prev_done   = done;
    prev_errcyc = HRESP && !HREADY;
    if (HTRANS == 2'b01) begin
      if (busy_cnt == 0) busy_addr = HADDR;
      else if (HADDR != busy_addr) busy_bad++;
      busy_cnt++;
    end
    if (!HREADY && !HRESP) begin wait_addr = HADDR; wait_trans = HTRANS; end
    if (HREADY && HTRANS[1]) begin
      if (n_acc < 16) begin
        acc_addr[n_acc] = HADDR; acc_trans[n_acc] = HTRANS; acc_burst[n_acc] = HBURST;
      end
      if (n_acc == 0) first_cyc = cyc;
      n_acc++;
    end
    if (HREADY && dp_valid && dp_write && n_wd < 16) begin wd_vals[n_wd] = HWDATA; n_wd++; end
    if (rdata_valid && n_rd < 16) begin rd_vals[n_rd] = rdata; n_rd++; end
    if (done) begin n_done++; done_cyc = cyc; if (cmd_ready) ready_at_done++; end
    if (err) begin n_err++; if (!done) lone_err++; end
    if (gap_left > 0 && w_idx == gap_idx) gap_left--;
    if (wdata_ready) w_idx++;
    if (cmd_valid && cmd_ready && (!cmd_write || wdata_valid)) cmd_taken = 1'b1;
    if (dp_valid && dp_beat == wait_beat && !HREADY) wait_done = 1'b1;
    if (dp_valid && dp_beat == err_beat) err_stage++;
    if (HREADY) begin dp_valid = HTRANS[1]; dp_addr = HADDR; dp_write = HWRITE; dp_beat = n_acc; end
  endtask

  task automatic start(input logic wr, input logic [31:0] addr, input logic [2:0] burst);
    cmd_write = wr; cmd_addr = addr; cmd_burst = burst; cmd_pend = 1'b1;
  endtask

  task automatic run_to_done(input string tag);
    for (int i = 0; i < 80 && !(n_done > 0 && cyc > done_cyc + 1); i++) cycle();
    check({tag, "_done_cnt"}, n_done, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_htrans"}, {30'd0, HTRANS}, 0);
    check({tag, "_haddr"}, HADDR, 0);
    check({tag, "_ctl"}, {HWRITE, HBURST, HSIZE}, 7'b0_000_010);
    check({tag, "_hwdata"}, HWDATA, 0);
    check({tag, "_flags"}, {cmd_ready, wdata_ready, rdata_valid, done, err}, 5'b00000);
  endtask

  initial begin
    rst_pending = 1'b1; cmd_pend = 1'b0; cmd_taken = 1'b0; dp_valid = 1'b0; dp_write = 1'b0;
    dp_addr = '0; dp_beat = 0; cyc = 0;
    HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_burst = '0;
    wdata = '0; wdata_valid = 1'b0;
    for (int i = 0; i < 16; i++) wq[i] = '0;
    clear_logs();

    cycle(); cycle();
    check_reset_state("por");
    rst_pending = 1'b0;
    cycle(); cycle();
    check("por_cmd_ready", {31'd0, cmd_ready}, 1);

    // write SINGLE
    clear_logs();
    wq[0] = 32'h1234_5678; n_words = 1;
    start(1'b1, 32'hA000_0000, 3'b000);
    run_to_done("single");
    check("single_beats", n_acc, 1);
    check("single_beat0", {acc_addr[0][31:0]}, 32'hA000_0000);
    check("single_type", {27'd0, acc_trans[0], acc_burst[0]}, {27'd0, 2'b10, 3'b000});
    check("single_hwdata", wd_vals[0], 32'h1234_5678);
    check("single_done_lat", done_cyc - first_cyc, 2);
    check("single_no_err", n_err, 0);
    check("single_ready_at_done", ready_at_done, 0);
    check("single_ready_after", ready_after_done, 1);

    // read INCR4, one wait state on beat 2
    clear_logs();
    rd_base = 32'hA000_0008; wait_beat = 2;
    start(1'b0, 32'hA000_0008, 3'b011);
    run_to_done("incr4");
    check("incr4_beats", n_acc, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("incr4_addr%0d", i), acc_addr[i], 32'hA000_0008 + 32'(4 * i));
      check($sformatf("incr4_trans%0d", i), {30'd0, acc_trans[i]}, (i == 0) ? 2 : 3);
    end
    check("incr4_wait_addr", wait_addr, 32'hA000_0010);
    check("incr4_wait_trans", {30'd0, wait_trans}, 3);
    check("incr4_rd_cnt", n_rd, 4);
    for (int i = 0; i < 4; i++) check($sformatf("incr4_rd%0d", i), rd_vals[i], 32'(i + 1));

    // write WRAP4 with a two-cycle gap before beat 3 (unaligned start address)
    clear_logs();
    wq[0] = 32'h1111_1111; wq[1] = 32'h2222_2222; wq[2] = 32'h3333_3333; wq[3] = 32'h4444_4444;
    n_words = 4; gap_idx = 2; gap_left = 2;
    start(1'b1, 32'hA000_003A, 3'b010);
    run_to_done("wrap4");
    check("wrap4_beats", n_acc, 4);
    check("wrap4_addr0", acc_addr[0], 32'hA000_0038);
    check("wrap4_addr1", acc_addr[1], 32'hA000_003C);
    check("wrap4_addr2", acc_addr[2], 32'hA000_0030);
    check("wrap4_addr3", acc_addr[3], 32'hA000_0034);
    check("wrap4_burst", {29'd0, acc_burst[3]}, 3'b010);
    check("wrap4_busy_cnt", busy_cnt, 2);
    check("wrap4_busy_addr", busy_addr, 32'hA000_0030);
    check("wrap4_busy_hold", busy_bad, 0);
    check("wrap4_wd_cnt", n_wd, 4);
    for (int i = 0; i < 4; i++) check($sformatf("wrap4_wd%0d", i), wd_vals[i], wq[i]);

    // write INCR8 across a 1 KB boundary
    clear_logs();
    for (int i = 0; i < 8; i++) wq[i] = 32'hC0DE_0000 + 32'(i);
    n_words = 8;
    start(1'b1, 32'h0000_03F8, 3'b101);
    run_to_done("incr8");
    check("incr8_beats", n_acc, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("incr8_addr%0d", i), acc_addr[i], 32'h0000_03F8 + 32'(4 * i));
      check($sformatf("incr8_trans%0d", i), {30'd0, acc_trans[i]}, (i == 0 || i == 2) ? 2 : 3);
    end
    check("incr8_burst1", {29'd0, acc_burst[1]}, 3'b101);
    check("incr8_burst2", {29'd0, acc_burst[2]}, 3'b001);
    check("incr8_burst7", {29'd0, acc_burst[7]}, 3'b001);
    check("incr8_busy", busy_cnt, 0);
    check("incr8_wd7", wd_vals[7], 32'hC0DE_0007);

    // read INCR8, ERROR on beat 3
    clear_logs();
    rd_base = 32'hB000_0000; err_beat = 3;
    start(1'b0, 32'hB000_0000, 3'b101);
    run_to_done("rderr");
    check("rderr_beats", n_acc, 3);
    check("rderr_idle_after", {30'd0, post_err_trans}, 0);
    check("rderr_rd_cnt", n_rd, 2);
    check("rderr_rd1", rd_vals[1], 2);
    check("rderr_err_cnt", n_err, 1);
    check("rderr_err_alone", lone_err, 0);

    // read INCR8, reset after three beats
    clear_logs();
    rd_base = 32'hC000_0000;
    start(1'b0, 32'hC000_0000, 3'b101);
    for (int i = 0; i < 40 && n_acc < 3; i++) cycle();
    check("rst_reached_beat3", n_acc, 3);
    rst_pending = 1'b1;
    cycle();
    rst_pending = 1'b0;
    dp_valid = 1'b0;
    cycle();
    check_reset_state("midrst");
    cycle();
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 1);
    for (int i = 0; i < 6; i++) cycle();
    check("midrst_no_done", n_done, 0);
    check("midrst_idle", {30'd0, HTRANS}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
